multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have the port `clk`, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-002 The block SHALL have the port `rst`, input, 1 bit: the reset, synchronous and active-high.
REQ-003 The block SHALL have the port `OpCode`, input, 6 bits: the opcode field from the instruction register output.
REQ-004 The block SHALL have the port `Zero`, input, 1 bit: the ALU equality flag.
REQ-005 The block SHALL have the port `MemReady`, input, 1 bit: unified memory completes the current access this cycle.
REQ-006 The block SHALL have the port `MemReq`, output, 1 bit: memory access request.
REQ-007 The block SHALL have the port `MemWrite`, output, 1 bit: the write qualifier for `MemReq`.
REQ-008 The block SHALL have the port `IorD`, output, 1 bit: memory address select (0 = PC, 1 = ALUOut).
REQ-009 The block SHALL have the port `IRWrite`, output, 1 bit: instruction register load.
REQ-010 The block SHALL have the port `PCEn`, output, 1 bit: PC load enable.
REQ-011 The block SHALL have the port `PCSrc`, output, 2 bits: next-PC select (00 = ALU result, 01 = ALUOut, 10 = jump target).
REQ-012 The block SHALL have the port `ALUSrcA`, output, 1 bit: ALU A select (0 = PC, 1 = register A).
REQ-013 The block SHALL have the port `ALUSrcB`, output, 2 bits: ALU B select (00 = register B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2).
REQ-014 The block SHALL have the port `ALUOp`, output, 2 bits: the code to the ALU decoder (00 = add, 01 = subtract, 10 = funct).
REQ-015 The block SHALL have the ports `RegWrite`, `RegDst` and `MemtoReg`, each output, 1 bit: register file write enable, destination select, and writeback select.
REQ-016 The block SHALL have the port `IllegalOp`, output, 1 bit: a one-cycle flag for an unsupported opcode.
REQ-017 The block SHALL have the port `State`, output, 4 bits: the current state code, for debug.

Function
REQ-018 The block SHALL use opcodes R-type = 000000, lw = 100011, sw = 101011, addi = 001000, beq = 000100, j = 000010.
REQ-019 The block SHALL be a 4-bit state register with codes FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5, EXECUTE = 6, ALUWB = 7, BRANCH = 8, ADDIEXEC = 9, ADDIWB = 10, JUMP = 11.
REQ-020 Outputs SHALL be combinational from state, with the `MemReady`/`Zero` qualifiers listed below; any output not listed for a state SHALL be 0.
REQ-021 FETCH SHALL drive MemReq = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSrc = 00.
REQ-022 In FETCH, IRWrite and PCEn SHALL equal MemReady, and the next state SHALL be DECODE if MemReady = 1, else FETCH.
REQ-023 DECODE SHALL drive ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00.
REQ-024 From DECODE, the next state SHALL be: lw/sw to MEMADR, R-type to EXECUTE, beq to BRANCH, addi to ADDIEXEC, j to JUMP.
REQ-025 From DECODE, any other opcode SHALL go to FETCH with IllegalOp = 1 for that cycle.
REQ-026 MEMADR SHALL drive ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00; the next state SHALL be MEMREAD for lw and MEMWRITE for sw.
REQ-027 MEMREAD SHALL drive MemReq = 1, IorD = 1, and hold until MemReady = 1, then go to MEMWB.
REQ-028 MEMWB SHALL drive RegWrite = 1, RegDst = 0, MemtoReg = 1, then go to FETCH.
REQ-029 MEMWRITE SHALL drive MemReq = 1, MemWrite = 1, IorD = 1, all held steady while waiting, and go to FETCH on MemReady = 1.
REQ-030 EXECUTE SHALL drive ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10, then go to ALUWB; ALUWB SHALL drive RegWrite = 1, RegDst = 1, MemtoReg = 0, then go to FETCH.
REQ-031 BRANCH SHALL drive ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCSrc = 01, PCEn = Zero, then go to FETCH.
REQ-032 ADDIEXEC SHALL drive ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00, then go to ADDIWB; ADDIWB SHALL drive RegWrite = 1, RegDst = 0, MemtoReg = 0, then go to FETCH.
REQ-033 JUMP SHALL drive PCSrc = 10, PCEn = 1, then go to FETCH.
REQ-034 Unused codes 12-15 SHALL drive all outputs 0 except State, and go to FETCH next cycle.
REQ-035 MemReady outside FETCH, MEMREAD and MEMWRITE SHALL be ignored.
REQ-036 Zero outside BRANCH SHALL be ignored.
REQ-037 Instruction latency with zero memory wait SHALL be: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles; each memory wait cycle SHALL add 1.

Reset
REQ-038 When `rst` = 1 at a rising edge, the state SHALL become FETCH regardless of the current state, including mid-access.
REQ-039 While `rst` = 1, all outputs except State SHALL be forced to 0, so that no MemReq, MemWrite, RegWrite or PCEn occurs during reset.
REQ-040 The first cycle after `rst` deasserts SHALL be FETCH, with State = 0 and MemReq = 1.

Verification
REQ-041 lw with MemReady held at 1: State SHALL sequence 0,1,2,3,4,0, with RegWrite = 1 and MemtoReg = 1 only in state 4.
REQ-042 sw with MemReady low for 2 cycles in MEMWRITE: MemWrite SHALL be 1 for 3 cycles, then State SHALL return to 0, with RegWrite never asserted.
REQ-043 beq with Zero = 1, then again with Zero = 0: PCEn SHALL be 1 and PCSrc = 01 in BRANCH for the first, and PCEn SHALL be 0 in BRANCH for the second.
REQ-044 Opcode 111111: DECODE SHALL go to FETCH with IllegalOp = 1 for exactly one cycle, and no RegWrite, MemReq or PCEn SHALL occur in that cycle.
REQ-045 rst asserted during MEMWRITE with MemReady = 0: MemWrite SHALL drop to 0 while rst = 1, and State SHALL = 0 after the edge.
REQ-046 R-type then j back-to-back with MemReady held at 1: State SHALL sequence 0,1,6,7,0,1,11,0, with IRWrite = 1 only in the two FETCH cycles.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style main controller: 12-state FSM that sequences fetch,
// decode and per-opcode execution. Memory states stall on MemReady.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] OpCode,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       MemReq,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCEn,
    output logic [1:0] PCSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       IllegalOp,
    output logic [3:0] State
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;

    state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    assign State = state_q;

    always_comb begin
        state_d   = S_FETCH;
        MemReq    = 1'b0;
        MemWrite  = 1'b0;
        IorD      = 1'b0;
        IRWrite   = 1'b0;
        PCEn      = 1'b0;
        PCSrc     = 2'b00;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ALUOp     = 2'b00;
        RegWrite  = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        IllegalOp = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemReq  = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PCEn    = MemReady;
                state_d = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (OpCode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEXEC;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        IllegalOp = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (OpCode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                MemReq  = 1'b1;
                IorD    = 1'b1;
                state_d = MemReady ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWRITE: begin
                MemReq   = 1'b1;
                MemWrite = 1'b1;
                IorD     = 1'b1;
                state_d  = MemReady ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b01;
                PCSrc   = 2'b01;
                PCEn    = Zero;
            end
            S_ADDIEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_JUMP: begin
                PCSrc = 2'b10;
                PCEn  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        // Reset masks every side-effecting strobe; only the debug state stays visible.
        if (rst) begin
            MemReq    = 1'b0;
            MemWrite  = 1'b0;
            IorD      = 1'b0;
            IRWrite   = 1'b0;
            PCEn      = 1'b0;
            PCSrc     = 2'b00;
            ALUSrcA   = 1'b0;
            ALUSrcB   = 2'b00;
            ALUOp     = 2'b00;
            RegWrite  = 1'b0;
            RegDst    = 1'b0;
            MemtoReg  = 1'b0;
            IllegalOp = 1'b0;
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed scenarios then random instruction
// streams, each expanded by an instruction-level model into per-cycle expectations.
module tb_multicycle_controller;
    logic       clk, rst, Zero, MemReady;
    logic [5:0] OpCode;
    logic       MemReq, MemWrite, IorD, IRWrite, PCEn, ALUSrcA;
    logic       RegWrite, RegDst, MemtoReg, IllegalOp;
    logic [1:0] PCSrc, ALUSrcB, ALUOp;
    logic [3:0] State;

    int checks = 0;
    int errors = 0;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .OpCode(OpCode), .Zero(Zero), .MemReady(MemReady),
        .MemReq(MemReq), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite),
        .PCEn(PCEn), .PCSrc(PCSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .IllegalOp(IllegalOp), .State(State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed as {MemReq,MemWrite,IorD,IRWrite,PCEn,PCSrc,ALUSrcA,
    // ALUSrcB,ALUOp,RegWrite,RegDst,MemtoReg,IllegalOp,State}.
    localparam logic [19:0] MR    = 20'd1 << 19;
    localparam logic [19:0] MW    = 20'd1 << 18;
    localparam logic [19:0] IOD   = 20'd1 << 17;
    localparam logic [19:0] IRW   = 20'd1 << 16;
    localparam logic [19:0] PCE   = 20'd1 << 15;
    localparam logic [19:0] PCS_A = 20'd1 << 13;
    localparam logic [19:0] PCS_J = 20'd2 << 13;
    localparam logic [19:0] ASA   = 20'd1 << 12;
    localparam logic [19:0] B4    = 20'd1 << 10;
    localparam logic [19:0] BIMM  = 20'd2 << 10;
    localparam logic [19:0] BSH   = 20'd3 << 10;
    localparam logic [19:0] SUB   = 20'd1 << 8;
    localparam logic [19:0] FUN   = 20'd2 << 8;
    localparam logic [19:0] RW    = 20'd1 << 7;
    localparam logic [19:0] RD    = 20'd1 << 6;
    localparam logic [19:0] M2R   = 20'd1 << 5;
    localparam logic [19:0] ILL   = 20'd1 << 4;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000, OP_BEQ = 6'b000100, OP_J = 6'b000010;

    function automatic logic [19:0] obs();
        return {MemReq, MemWrite, IorD, IRWrite, PCEn, PCSrc, ALUSrcA, ALUSrcB,
                ALUOp, RegWrite, RegDst, MemtoReg, IllegalOp, State};
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        return op == OP_R || op == OP_LW || op == OP_SW || op == OP_ADDI ||
               op == OP_BEQ || op == OP_J;
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // One clock: drive inputs just after the edge, compare at the falling edge.
    task automatic step(input logic [5:0] op, input logic mrdy, input logic z,
                        input logic [19:0] exp, input string tag);
        logic [19:0] o;
        OpCode   = op;
        MemReady = mrdy;
        Zero     = z;
        @(negedge clk);
        o = obs();
        checks++;
        assert (o === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, o, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int fw);
        for (int i = 0; i < fw; i++) step(6'($urandom), 1'b0, rb(), MR | B4, "fetch_wait");
        step(6'($urandom), 1'b1, rb(), MR | B4 | IRW | PCE, "fetch");
    endtask

    // Expands one instruction into its cycle-by-cycle expected outputs.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic z);
        fetch(fw);
        step(op, rb(), rb(), BSH | 20'd1 | (is_legal(op) ? 20'd0 : ILL), "decode");
        case (op)
            OP_LW: begin
                step(op, rb(), rb(), ASA | BIMM | 20'd2, "lw_memadr");
                for (int i = 0; i < mw; i++) step(op, 1'b0, rb(), MR | IOD | 20'd3, "memread_wait");
                step(op, 1'b1, rb(), MR | IOD | 20'd3, "memread");
                step(op, rb(), rb(), RW | M2R | 20'd4, "memwb");
            end
            OP_SW: begin
                step(op, rb(), rb(), ASA | BIMM | 20'd2, "sw_memadr");
                for (int i = 0; i < mw; i++) step(op, 1'b0, rb(), MR | MW | IOD | 20'd5, "memwrite_wait");
                step(op, 1'b1, rb(), MR | MW | IOD | 20'd5, "memwrite");
            end
            OP_R: begin
                step(op, rb(), rb(), ASA | FUN | 20'd6, "execute");
                step(op, rb(), rb(), RW | RD | 20'd7, "aluwb");
            end
            OP_BEQ: step(op, rb(), z, ASA | SUB | PCS_A | (z ? PCE : 20'd0) | 20'd8, "branch");
            OP_ADDI: begin
                step(op, rb(), rb(), ASA | BIMM | 20'd9, "addiexec");
                step(op, rb(), rb(), RW | 20'd10, "addiwb");
            end
            OP_J: step(op, rb(), rb(), PCS_J | PCE | 20'd11, "jump");
            default: ;
        endcase
    endtask

    initial begin
        logic [5:0] op;
        rst = 1'b1; OpCode = '0; Zero = 1'b0; MemReady = 1'b1;
        @(posedge clk); #1;
        step(6'h23, 1'b1, 1'b1, 20'd0, "reset_hold");
        step(6'h2b, 1'b1, 1'b1, 20'd0, "reset_hold2");
        rst = 1'b0;

        run_instr(OP_LW, 0, 0, 1'b0);
        run_instr(OP_SW, 0, 2, 1'b0);
        run_instr(OP_BEQ, 0, 0, 1'b1);
        run_instr(OP_BEQ, 0, 0, 1'b0);
        run_instr(6'b111111, 0, 0, 1'b0);
        run_instr(OP_R, 0, 0, 1'b0);
        run_instr(OP_J, 0, 0, 1'b0);
        run_instr(OP_ADDI, 1, 0, 1'b0);
        run_instr(OP_LW, 2, 3, 1'b0);

        // Reset while a store is stalled: strobes drop during reset, FETCH follows.
        fetch(0);
        step(OP_SW, 1'b1, 1'b0, BSH | 20'd1, "decode");
        step(OP_SW, 1'b1, 1'b0, ASA | BIMM | 20'd2, "sw_memadr");
        step(OP_SW, 1'b0, 1'b0, MR | MW | IOD | 20'd5, "memwrite_wait");
        rst = 1'b1;
        step(OP_SW, 1'b0, 1'b1, 20'd5, "rst_in_memwrite");
        rst = 1'b0;
        run_instr(OP_ADDI, 0, 0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 6))
                0: op = OP_R;
                1: op = OP_LW;
                2: op = OP_SW;
                3: op = OP_ADDI;
                4: op = OP_BEQ;
                5: op = OP_J;
                default: begin
                    op = 6'($urandom);
                    while (is_legal(op)) op = 6'($urandom);
                end
            endcase
            run_instr(op, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                      ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0, rb());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
